// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: one A/B bit pair per in_valid/in_ready transfer,
// one-hot gt/eq/lt result held on res_valid until res_ready (DONE blocks further input).
module serial_mag_comparator #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   localparam int CW       = $clog2(WIDTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          a_bit,
   input  logic          b_bit,
   output logic          res_valid,
   input  logic          res_ready,
   output logic          a_gt_b,
   output logic          a_eq_b,
   output logic          a_lt_b,
   output logic [CW-1:0] bit_cnt
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t        state_q;
   logic          in_ready_q;
   logic          res_valid_q;
   logic          differ_q, differ_d;
   logic          gt_q, gt_d;
   logic          gt_flag_q, eq_flag_q, lt_flag_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          xfer;
   logic          last;

   assign xfer = in_valid && in_ready_q;
   assign cnt_d = cnt_q + 1'b1;
   assign last = (cnt_d == CW'(WIDTH));

   // MSB-first locks on the first difference; LSB-first lets each later difference override.
   always_comb begin
      differ_d = differ_q;
      gt_d     = gt_q;
      if ((a_bit != b_bit) && (!MSB_FIRST || !differ_q)) begin
         differ_d = 1'b1;
         gt_d     = a_bit;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         differ_q    <= 1'b0;
         gt_q        <= 1'b0;
         gt_flag_q   <= 1'b0;
         eq_flag_q   <= 1'b0;
         lt_flag_q   <= 1'b0;
         cnt_q       <= '0;
      end else if (clear) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         res_valid_q <= 1'b0;
         differ_q    <= 1'b0;
         gt_q        <= 1'b0;
         cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE, SHIFT: begin
               in_ready_q <= 1'b1;
               if (xfer) begin
                  differ_q <= differ_d;
                  gt_q     <= gt_d;
                  cnt_q    <= cnt_d;
                  if (last) begin
                     state_q     <= DONE;
                     in_ready_q  <= 1'b0;
                     res_valid_q <= 1'b1;
                     gt_flag_q   <= differ_d & gt_d;
                     eq_flag_q   <= ~differ_d;
                     lt_flag_q   <= differ_d & ~gt_d;
                  end else begin
                     state_q <= SHIFT;
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  state_q     <= IDLE;
                  in_ready_q  <= 1'b1;
                  res_valid_q <= 1'b0;
                  differ_q    <= 1'b0;
                  gt_q        <= 1'b0;
                  cnt_q       <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign res_valid = res_valid_q;
   assign a_gt_b    = gt_flag_q;
   assign a_eq_b    = eq_flag_q;
   assign a_lt_b    = lt_flag_q;
   assign bit_cnt   = cnt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: three configurations (W8 MSB-first, W8 LSB-first,
// W2 LSB-first) checked every cycle against an integer-level operand model.
module tb_serial_mag_comparator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] clr = '0, iv = '0, ab = '0, bb = '0, rr = 3'b111;
   logic [2:0] rdy_w, rv_w, gt_w, eq_w, lt_w;
   logic [3:0] cnt0, cnt1;
   logic [1:0] cnt2;
   logic [3:0] cnt_w [3];
   bit         chk_en = 1'b0;

   int n_chk = 0;
   int n_pass = 0;

   int W   [3] = '{8, 8, 2};
   bit MSB [3] = '{1'b1, 1'b0, 1'b0};

   // Model: operands accumulated as integers, result from a plain integer compare.
   int         m_cnt [3] = '{0, 0, 0};
   int         m_a   [3] = '{0, 0, 0};
   int         m_b   [3] = '{0, 0, 0};
   bit         m_rdy [3] = '{1'b0, 1'b0, 1'b0};
   bit         m_rv  [3] = '{1'b0, 1'b0, 1'b0};
   logic [2:0] m_fl  [3] = '{3'b000, 3'b000, 3'b000};

   always #5 clk = ~clk;

   serial_mag_comparator #(.WIDTH(8), .MSB_FIRST(1'b1)) u0 (
      .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .in_ready(rdy_w[0]),
      .a_bit(ab[0]), .b_bit(bb[0]), .res_valid(rv_w[0]), .res_ready(rr[0]),
      .a_gt_b(gt_w[0]), .a_eq_b(eq_w[0]), .a_lt_b(lt_w[0]), .bit_cnt(cnt0));

   serial_mag_comparator #(.WIDTH(8), .MSB_FIRST(1'b0)) u1 (
      .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(iv[1]), .in_ready(rdy_w[1]),
      .a_bit(ab[1]), .b_bit(bb[1]), .res_valid(rv_w[1]), .res_ready(rr[1]),
      .a_gt_b(gt_w[1]), .a_eq_b(eq_w[1]), .a_lt_b(lt_w[1]), .bit_cnt(cnt1));

   serial_mag_comparator #(.WIDTH(2), .MSB_FIRST(1'b0)) u2 (
      .clk(clk), .rst_n(rst_n), .clear(clr[2]), .in_valid(iv[2]), .in_ready(rdy_w[2]),
      .a_bit(ab[2]), .b_bit(bb[2]), .res_valid(rv_w[2]), .res_ready(rr[2]),
      .a_gt_b(gt_w[2]), .a_eq_b(eq_w[2]), .a_lt_b(lt_w[2]), .bit_cnt(cnt2));

   assign cnt_w[0] = cnt0;
   assign cnt_w[1] = cnt1;
   assign cnt_w[2] = {2'b00, cnt2};

   task automatic chk(input string nm, input int id, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s[dut%0d] @%0t: got %0d, expected %0d", nm, id, $time, act, exp);
   endtask

   task automatic tmo(input string nm, input int id);
      n_chk++;
      $display("FAIL timeout %s[dut%0d] @%0t: DUT event not seen within budget", nm, id, $time);
   endtask

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            m_cnt[i] = 0; m_a[i] = 0; m_b[i] = 0;
            m_rdy[i] = 1'b0; m_rv[i] = 1'b0; m_fl[i] = 3'b000;
         end else if (clr[i]) begin
            m_cnt[i] = 0; m_a[i] = 0; m_b[i] = 0;
            m_rdy[i] = 1'b1; m_rv[i] = 1'b0;
         end else if (m_rv[i]) begin
            if (rr[i]) begin
               m_cnt[i] = 0; m_a[i] = 0; m_b[i] = 0;
               m_rdy[i] = 1'b1; m_rv[i] = 1'b0;
            end
         end else begin
            bit acc;
            acc = iv[i] && m_rdy[i];
            m_rdy[i] = 1'b1;
            if (acc) begin
               if (MSB[i]) begin
                  m_a[i] = (m_a[i] << 1) | int'(ab[i]);
                  m_b[i] = (m_b[i] << 1) | int'(bb[i]);
               end else begin
                  m_a[i] = m_a[i] | (int'(ab[i]) << m_cnt[i]);
                  m_b[i] = m_b[i] | (int'(bb[i]) << m_cnt[i]);
               end
               m_cnt[i]++;
               if (m_cnt[i] == W[i]) begin
                  m_rv[i]  = 1'b1;
                  m_rdy[i] = 1'b0;
                  m_fl[i]  = (m_a[i] > m_b[i]) ? 3'b100 : (m_a[i] == m_b[i]) ? 3'b010 : 3'b001;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk("in_ready", i, rdy_w[i], m_rdy[i]);
            chk("res_valid", i, rv_w[i], m_rv[i]);
            chk("bit_cnt", i, cnt_w[i], m_cnt[i]);
            if (m_rv[i]) chk("flags", i, {gt_w[i], eq_w[i], lt_w[i]}, m_fl[i]);
         end
      end
   end

   // Sends bits k0..k1-1 of A/B in the configured order, with optional random in_valid gaps.
   task automatic send(input int id, input int a, input int b, input int k0, input int k1,
                       input int gapmax);
      for (int k = k0; k < k1; k++) begin
         int idx;
         int g;
         int to;
         bit got;
         idx = MSB[id] ? (W[id] - 1 - k) : k;
         g = 0;
         if (gapmax > 0 && $urandom_range(3, 0) == 0) g = $urandom_range(gapmax, 1);
         repeat (g) begin
            iv[id] = 1'b0;
            @(posedge clk); #1;
         end
         iv[id] = 1'b1;
         ab[id] = a[idx];
         bb[id] = b[idx];
         got = 1'b0;
         to = 0;
         while (!got) begin
            @(negedge clk);
            got = rdy_w[id];
            @(posedge clk); #1;
            to++;
            if (!got && to > 200) begin
               tmo("accept", id);
               iv[id] = 1'b0;
               return;
            end
         end
      end
      iv[id] = 1'b0;
   endtask

   task automatic done(input int id);
      int to;
      rr[id] = 1'b1;
      to = 0;
      while (rv_w[id]) begin
         @(posedge clk); #1;
         to++;
         if (to > 50) begin
            tmo("handshake", id);
            return;
         end
      end
   endtask

   task automatic chk_reset_vals(input string nm, input int id);
      chk({nm, "_rdy"}, id, rdy_w[id], 0);
      chk({nm, "_rv"}, id, rv_w[id], 0);
      chk({nm, "_cnt"}, id, cnt_w[id], 0);
      chk({nm, "_flags"}, id, {gt_w[id], eq_w[id], lt_w[id]}, 0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) chk_reset_vals("por", i);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rdy_before_edge", 0, rdy_w[0], 0);
      @(posedge clk); #1;
      chk("rdy_first_edge", 0, rdy_w, 3'b111);

      // Basic MSB-first compare with result latency
      send(0, 'hA5, 'hA3, 0, 8, 0);
      chk("t1_rv", 0, rv_w[0], 1);
      chk("t1_flags", 0, {gt_w[0], eq_w[0], lt_w[0]}, 3'b100);
      chk("t1_cnt", 0, cnt_w[0], 8);
      chk("t1_model", 0, m_fl[0], 3'b100);
      done(0);

      send(0, 'h3C, 'h3C, 0, 8, 0);
      chk("t2_eq", 0, {gt_w[0], eq_w[0], lt_w[0]}, 3'b010);
      done(0);
      send(0, 'h00, 'h80, 0, 7, 0);
      chk("t2_early_rv", 0, rv_w[0], 0);
      send(0, 'h00, 'h80, 7, 8, 0);
      chk("t2_lt", 0, {gt_w[0], eq_w[0], lt_w[0]}, 3'b001);
      done(0);

      // LSB-first literals and exhaustive 2-bit sweep
      send(1, 'h01, 'h80, 0, 8, 0);
      chk("t3_lt", 1, {gt_w[1], eq_w[1], lt_w[1]}, 3'b001);
      chk("t3_model", 1, m_fl[1], 3'b001);
      done(1);
      send(1, 'hFF, 'h7F, 0, 8, 0);
      chk("t3_gt", 1, {gt_w[1], eq_w[1], lt_w[1]}, 3'b100);
      done(1);
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            send(2, a, b, 0, 2, 0);
            chk("sweep", 2, {gt_w[2], eq_w[2], lt_w[2]}, (a > b) ? 4 : (a == b) ? 2 : 1);
            done(2);
         end
      end

      // Result backpressure with stray in_valid pulses
      rr[0] = 1'b0;
      send(0, 'h12, 'h34, 0, 8, 0);
      repeat (10) begin
         iv[0] = 1'($urandom_range(1, 0));
         ab[0] = 1'($urandom_range(1, 0));
         bb[0] = 1'($urandom_range(1, 0));
         @(posedge clk); #1;
      end
      iv[0] = 1'b0;
      chk("t4_rv_held", 0, rv_w[0], 1);
      chk("t4_rdy_low", 0, rdy_w[0], 0);
      chk("t4_flags", 0, {gt_w[0], eq_w[0], lt_w[0]}, 3'b001);
      done(0);
      chk("t4_rdy_back", 0, rdy_w[0], 1);
      chk("t4_cnt_zero", 0, cnt_w[0], 0);

      // clear mid-operand and clear coincident with the final transfer
      send(0, 'h55, 'h55, 0, 4, 0);
      clr[0] = 1'b1;
      @(posedge clk); #1;
      clr[0] = 1'b0;
      chk("t5_cnt_clr", 0, cnt_w[0], 0);
      send(0, 'h10, 'h0F, 0, 8, 0);
      chk("t5_gt", 0, {gt_w[0], eq_w[0], lt_w[0]}, 3'b100);
      chk("t5_cnt", 0, cnt_w[0], 8);
      done(0);
      send(0, 'hFF, 'h00, 0, 7, 0);
      iv[0] = 1'b1; ab[0] = 1'b1; bb[0] = 1'b0; clr[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0; clr[0] = 1'b0;
      chk("t5_no_res", 0, rv_w[0], 0);
      chk("t5_cnt_zero", 0, cnt_w[0], 0);
      repeat (3) begin @(posedge clk); #1; end
      chk("t5_still_no_res", 0, rv_w[0], 0);

      // Asynchronous reset mid-SHIFT and in DONE
      send(0, 'hAA, 'h55, 0, 3, 0);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_shift", 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      rr[0] = 1'b0;
      send(0, 'hC3, 'h3C, 0, 8, 0);
      chk("t6_done", 0, rv_w[0], 1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("rst_done", 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rr[0] = 1'b1;
      @(posedge clk); #1;

      // Randomized operands, gaps, backpressure and occasional aborts
      for (int n = 0; n < 1000; n++) begin
         int id;
         int msk;
         int a;
         int b;
         id  = $urandom_range(2, 0);
         msk = (1 << W[id]) - 1;
         a   = int'($urandom) & msk;
         b   = int'($urandom) & msk;
         if ($urandom_range(19, 0) == 0) begin
            send(id, a, b, 0, $urandom_range(W[id] - 1, 1), 2);
            clr[id] = 1'b1;
            @(posedge clk); #1;
            clr[id] = 1'b0;
         end
         rr[id] = 1'($urandom_range(1, 0));
         send(id, a, b, 0, W[id], 3);
         repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
         done(id);
      end

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
